// File: rtl/sdram_avm_master_pkg.sv
// Shared constants and state encoding for the SDRAM Avalon-MM master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sdram_avm_master_pkg;

  localparam int DEF_ADDR_W = 24;
  localparam int DEF_DATA_W = 16;

  // Width of the outstanding-read counter (MAX_PENDING is limited to 1..15).
  localparam int CNT_W = 4;

  // Byteenable_n value for an inactive bus. Slice to the bus width in use.
  localparam logic [63:0] BE_NONE = '1;

  // IDLE: no command register; ISSUE: command register valid on the bus.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/sdram_avm_pending_ctr.sv
// Outstanding-read counter: +1 per read loaded, -1 per read returned.
// Latency: count updates on the next edge; next value exposed combinationally.
// Backpressure: saturates at MAX_PENDING and at zero; full/empty gate the caller.
module sdram_avm_pending_ctr
  import sdram_avm_master_pkg::*;
#(
  parameter int MAX_PENDING = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_nxt_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: a simultaneous load and return cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_nxt_o = cnt_d;
  assign full_o    = (cnt_q == CNT_MAX);
  assign empty_o   = (cnt_q == '0);

endmodule

// File: rtl/sdram_avm_master.sv
// Avalon-MM master for the SDRAM s1 port: single-word host requests, pipelined reads.
// Latency: command on bus the edge after host accept; read data 1 cycle after readdatavalid.
// Backpressure: req_ready follows waitrequest and the outstanding-read limit; no rsp backpressure.
module sdram_avm_master
  import sdram_avm_master_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MAX_PENDING  = 4,
  parameter int WAIT_TIMEOUT = 1024,
  parameter int BE_W         = DATA_W / 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              idle,
  output logic              err_timeout,
  output logic              err_stray,
  output logic [ADDR_W-1:0] avm_address,
  output logic [BE_W-1:0]   avm_byteenable_n,
  output logic              avm_chipselect,
  output logic [DATA_W-1:0] avm_writedata,
  output logic              avm_read_n,
  output logic              avm_write_n,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
);

  localparam int               STALL_W   = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(WAIT_TIMEOUT);
  localparam logic [BE_W-1:0]  BE_OFF    = BE_NONE[BE_W-1:0];

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [BE_W-1:0]     be_n_q;
  logic                cs_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                read_n_q, write_n_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                idle_q;
  logic                err_timeout_q, err_stray_q;
  logic [STALL_W-1:0]  stall_q, stall_d;

  logic                bus_accept, host_acc, rd_load, rd_done, stray;
  logic                full, empty;
  logic [CNT_W-1:0]    inflight_nxt;

  // Handshake decode, next state and stall counting.
  always_comb begin
    bus_accept = (state_q == ST_ISSUE) && cs_q && !avm_waitrequest;
    req_ready  = ((state_q == ST_IDLE) || bus_accept) && !full;
    host_acc   = req_valid && req_ready;
    rd_load    = host_acc && !req_write;
    rd_done    = avm_readdatavalid && !empty;
    stray      = avm_readdatavalid && empty;

    state_d = state_q;
    if (host_acc) begin
      state_d = ST_ISSUE;
    end else if (bus_accept) begin
      state_d = ST_IDLE;
    end

    stall_d = stall_q;
    if (bus_accept) begin
      stall_d = '0;
    end else if ((state_q == ST_ISSUE) && avm_waitrequest && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  sdram_avm_pending_ctr #(
    .MAX_PENDING (MAX_PENDING)
  ) u_pending (
    .clk_i     (clk_clk),
    .rst_i     (reset_reset),
    .inc_i     (rd_load),
    .dec_i     (rd_done),
    .cnt_nxt_o (inflight_nxt),
    .full_o    (full),
    .empty_o   (empty)
  );

  // Command FSM with registered Avalon outputs; a stalled command is never abandoned.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q   <= ST_IDLE;
      cs_q      <= 1'b0;
      read_n_q  <= 1'b1;
      write_n_q <= 1'b1;
      be_n_q    <= BE_OFF;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (host_acc) begin
        cs_q      <= 1'b1;
        read_n_q  <= req_write;
        write_n_q <= !req_write;
        be_n_q    <= req_write ? ~req_be : '0;
        addr_q    <= req_addr;
        wdata_q   <= req_wdata;
      end else if (bus_accept) begin
        cs_q      <= 1'b0;
        read_n_q  <= 1'b1;
        write_n_q <= 1'b1;
        be_n_q    <= BE_OFF;
      end
    end
  end

  // Read response, status flags and the timeout stall counter.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      idle_q        <= 1'b1;
      err_timeout_q <= 1'b0;
      err_stray_q   <= 1'b0;
      stall_q       <= '0;
    end else begin
      rsp_valid_q <= rd_done;
      if (rd_done) begin
        rsp_data_q <= avm_readdata;
      end
      idle_q  <= (state_d == ST_IDLE) && (inflight_nxt == '0);
      stall_q <= stall_d;
      if (stall_d == STALL_MAX) begin
        err_timeout_q <= 1'b1;
      end
      if (stray) begin
        err_stray_q <= 1'b1;
      end
    end
  end

  assign avm_address      = addr_q;
  assign avm_byteenable_n = be_n_q;
  assign avm_chipselect   = cs_q;
  assign avm_writedata    = wdata_q;
  assign avm_read_n       = read_n_q;
  assign avm_write_n      = write_n_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_data         = rsp_data_q;
  assign idle             = idle_q;
  assign err_timeout      = err_timeout_q;
  assign err_stray        = err_stray_q;

endmodule
